// File: rtl/scope_capture_if.sv
// Sample-input and frame-readout signals of the scope capture block.
// The master drives samples and read requests; the slave returns frame data.
interface scope_capture_if #(
    parameter int CH = 2,
    parameter int W  = 12
);
    logic            s_valid;
    logic [CH*W-1:0] s_data;
    logic            rd_en;
    logic [CH*W-1:0] rd_data;
    logic            rd_valid;

    modport master (output s_valid, s_data, rd_en, input rd_data, rd_valid);
    modport slave  (input s_valid, s_data, rd_en, output rd_data, rd_valid);
endinterface

// File: rtl/scope_capture.sv
// Multi-channel oscilloscope capture: circular pre-trigger buffer, edge/auto
// trigger, post-trigger fill, then oldest-first readout of one frame.
module scope_capture #(
    parameter int CH      = 2,
    parameter int W       = 12,
    parameter int DEPTH   = 256,
    parameter int PRE     = DEPTH / 2,
    parameter int AUTO_TO = 1024
) (
    input  logic                                   clk,
    input  logic                                   reset,
    scope_capture_if.slave                         bus,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] trig_sel,
    input  logic [W-1:0]                           trig_level,
    input  logic                                   trig_edge,
    input  logic [1:0]                             mode,
    input  logic [5:0]                             decim,
    input  logic                                   arm,
    output logic                                   frame_ready,
    output logic                                   triggered,
    output logic [2:0]                             state
);
    localparam int SELW = (CH > 1) ? $clog2(CH) : 1;
    localparam int AW   = $clog2(DEPTH);
    localparam int TW   = $clog2(AUTO_TO + 1);
    localparam logic [AW:0]   PRE_N  = (AW+1)'(PRE);
    localparam logic [AW:0]   POST_N = (AW+1)'(DEPTH - PRE);
    localparam logic [AW:0]   LAST_N = (AW+1)'(DEPTH - 1);
    localparam logic [TW-1:0] AUTO_N = TW'(AUTO_TO);
    localparam logic [AW-1:0] PRE_A  = AW'(PRE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_READY = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wptr_q, wptr_d, trig_ptr_q, trig_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [TW-1:0]   auto_q, auto_d;
    logic [5:0]      dec_q, dec_d;
    logic [CH*W-1:0] prev_q, prev_d, rd_data_q, rd_data_d;
    logic            rd_valid_q, rd_valid_d, frame_ready_q, frame_ready_d;
    logic            triggered_q, triggered_d;
    logic [CH*W-1:0] mem [DEPTH];

    logic            we, acc, hit, rearm, capturing;
    logic [SELW-1:0] sel;
    logic [W-1:0]    cur_s, prev_s;

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        trig_ptr_d = trig_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        auto_d     = auto_q;
        dec_d      = dec_q;
        prev_d     = prev_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        we         = 1'b0;
        hit        = 1'b0;
        rearm      = 1'b0;
        sel        = (int'(trig_sel) < CH) ? trig_sel : '0;
        cur_s      = bus.s_data[int'(sel)*W +: W];
        prev_s     = prev_q[int'(sel)*W +: W];
        capturing  = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
        acc        = capturing && bus.s_valid && (dec_q == 6'd0);
        if (capturing && bus.s_valid)
            dec_d = (dec_q >= decim) ? 6'd0 : dec_q + 6'd1;

        // cnt_q is shared: PRE fill count, POST fill count, then read count
        unique case (state_q)
            S_IDLE: rearm = arm;
            S_PRE: if (acc) begin
                we    = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q + 1'b1 == PRE_N) begin
                    state_d = S_ARMED;
                    cnt_d   = '0;
                end
            end
            S_ARMED: if (acc) begin
                we     = 1'b1;
                auto_d = auto_q + 1'b1;
                hit    = trig_edge ? (prev_s >= trig_level && trig_level > cur_s)
                                   : (prev_s < trig_level && trig_level <= cur_s);
                if (mode == 2'b01 && auto_d == AUTO_N) hit = 1'b1;
                if (hit) begin
                    trig_ptr_d = wptr_q;
                    cnt_d      = (AW+1)'(1);
                    state_d    = S_POST;
                end
            end
            S_POST: begin
                if (cnt_q >= POST_N) begin
                    state_d = S_READY;
                end else if (acc) begin
                    we    = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == POST_N) state_d = S_READY;
                end
            end
            S_READY: if (bus.rd_en) begin
                rd_valid_d = 1'b1;
                rd_data_d  = mem[rd_ptr_q];
                rd_ptr_d   = rd_ptr_q + 1'b1;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LAST_N) begin
                    if (mode == 2'b10) state_d = S_IDLE;
                    else               rearm   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (we) begin
            wptr_d = wptr_q + 1'b1;
            prev_d = bus.s_data;
        end
        // Oldest sample of the frame sits PRE slots before the trigger sample
        if (state_q != S_READY && state_d == S_READY) begin
            rd_ptr_d = trig_ptr_d - PRE_A;
            cnt_d    = '0;
        end
        if (rearm) begin
            state_d = S_PRE;
            wptr_d  = '0;
            cnt_d   = '0;
            auto_d  = '0;
            dec_d   = '0;
        end
        frame_ready_d = (state_d == S_READY);
        triggered_d   = (state_d == S_POST) || (state_d == S_READY);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            wptr_q        <= '0;
            trig_ptr_q    <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
            auto_q        <= '0;
            dec_q         <= '0;
            prev_q        <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            frame_ready_q <= 1'b0;
            triggered_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wptr_q        <= wptr_d;
            trig_ptr_q    <= trig_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cnt_q         <= cnt_d;
            auto_q        <= auto_d;
            dec_q         <= dec_d;
            prev_q        <= prev_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            frame_ready_q <= frame_ready_d;
            triggered_q   <= triggered_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && we) mem[wptr_q] <= bus.s_data;
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign frame_ready  = frame_ready_q;
    assign triggered    = triggered_q;
    assign state        = state_q;
endmodule

// File: tb/tb_scope_capture.sv
// Randomized and directed bench for scope_capture against a sample-list model:
// the frame is taken straight from the list of samples accepted since arm.
module tb_scope_capture;
    localparam int CH = 2, W = 12, DEPTH = 16, PRE = 4, AUTO_TO = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    scope_capture_if #(.CH(CH), .W(W)) bus ();
    logic         trig_sel;
    logic [W-1:0] trig_level;
    logic         trig_edge;
    logic [1:0]   mode;
    logic [5:0]   decim;
    logic         arm;
    logic         frame_ready, triggered;
    logic [2:0]   state;

    scope_capture #(.CH(CH), .W(W), .DEPTH(DEPTH), .PRE(PRE), .AUTO_TO(AUTO_TO)) dut (
        .clk(clk), .reset(reset), .bus(bus), .trig_sel(trig_sel), .trig_level(trig_level),
        .trig_edge(trig_edge), .mode(mode), .decim(decim), .arm(arm),
        .frame_ready(frame_ready), .triggered(triggered), .state(state)
    );

    int checks = 0, failures = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int              m_phase;      // 0 idle, 1 capturing, 2 frame held
    logic [CH*W-1:0] m_smp[$];     // every sample accepted since arm
    int              m_strobes, m_trig, m_rd;
    logic            m_rv;
    logic [CH*W-1:0] m_rd_data;

    function automatic logic [W-1:0] m_ch(int idx, int ch);
        logic [CH*W-1:0] v;
        v = m_smp[idx];
        return v[ch*W +: W];
    endfunction

    function automatic void start_capture();
        m_phase = 1;
        m_smp.delete();
        m_strobes = 0;
        m_trig = -1;
        m_rd = 0;
    endfunction

    function automatic void take(logic [CH*W-1:0] d);
        int i, sel;
        logic [W-1:0] p, c;
        i = m_smp.size();
        sel = (int'(trig_sel) < CH) ? int'(trig_sel) : 0;
        m_smp.push_back(d);
        if (i >= PRE && m_trig < 0) begin
            p = m_ch(i - 1, sel);
            c = m_ch(i, sel);
            if (trig_edge ? (p >= trig_level && trig_level > c) : (p < trig_level && trig_level <= c))
                m_trig = i;
            if (mode == 2'b01 && i - PRE + 1 == AUTO_TO) m_trig = i;
        end
        if (m_trig >= 0 && i + 1 - m_trig == DEPTH - PRE) m_phase = 2;
    endfunction

    function automatic int exp_state();
        if (m_phase == 0) return 0;
        if (m_phase == 2) return 4;
        if (m_smp.size() < PRE) return 1;
        if (m_trig < 0) return 2;
        return 3;
    endfunction

    initial begin
        m_phase = 0; m_strobes = 0; m_trig = -1; m_rd = 0; m_rv = 1'b0; m_rd_data = '0;
        forever begin
            @(posedge clk);
            m_rv = 1'b0;
            if (!reset) begin
                m_phase = 0;
                m_rd_data = '0;
            end else begin
                case (m_phase)
                    0: if (arm) start_capture();
                    1: if (bus.s_valid) begin
                        if (m_strobes % (int'(decim) + 1) == 0) take(bus.s_data);
                        m_strobes++;
                    end
                    default: if (bus.rd_en) begin
                        m_rv = 1'b1;
                        m_rd_data = m_smp[m_trig - PRE + m_rd];
                        m_rd++;
                        if (m_rd == DEPTH) begin
                            if (mode == 2'b10) m_phase = 0;
                            else start_capture();
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("state", 32'(state), 32'(exp_state()));
                chk("frame_ready", 32'(frame_ready), 32'(m_phase == 2));
                chk("triggered", 32'(triggered), 32'(exp_state() >= 3));
                chk("rd_valid", 32'(bus.rd_valid), 32'(m_rv));
                if (m_rv) chk("rd_data", 32'(bus.rd_data), 32'(m_rd_data));
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: run did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    logic [CH*W-1:0] rd_log[$];

    function automatic logic [W-1:0] rd_ch(int idx, int ch);
        logic [CH*W-1:0] v;
        v = rd_log[idx];
        return v[ch*W +: W];
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic capture(input logic [1:0] md, input logic edg, input logic [W-1:0] lvl,
                           input logic sel, input logic [5:0] dc, input int kind, input int base,
                           input bit stop_post, output int k);
        int cyc;
        logic [W-1:0] a, r;
        mode = md; trig_edge = edg; trig_level = lvl; trig_sel = sel; decim = dc;
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        k = 0;
        cyc = 0;
        while (!frame_ready && !(stop_post && state == 3'd3) && cyc < 3000) begin
            bus.s_valid = ($urandom_range(0, 3) != 0);
            if (bus.s_valid) begin
                r = W'($urandom_range(0, 4095));
                case (kind)
                    0: begin a = W'(base + k); bus.s_data = {r, a}; end
                    1: begin a = W'(base - k); bus.s_data = {a, r}; end
                    default: begin a = W'(base); bus.s_data = {r, a}; end
                endcase
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.s_valid = 1'b0;
        if (stop_post) chk("post_reached", 32'(state), 32'd3);
        else           chk("frame_done", 32'(frame_ready), 32'd1);
    endtask

    task automatic read_frame();
        int issued, cyc;
        issued = 0;
        cyc = 0;
        rd_log.delete();
        while (rd_log.size() < DEPTH && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (bus.rd_valid) rd_log.push_back(bus.rd_data);
            bus.rd_en = (issued < DEPTH) && ($urandom_range(0, 3) != 0);
            if (bus.rd_en) issued++;
        end
        bus.rd_en = 1'b0;
        chk("read_count", 32'(rd_log.size()), 32'(DEPTH));
    endtask

    initial begin
        int k;
        reset = 1'b0; arm = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0; bus.rd_en = 1'b0;
        trig_sel = 1'b0; trig_level = '0; trig_edge = 1'b0; mode = 2'b00; decim = '0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_frame_ready", 32'(frame_ready), 32'd0);
        chk("rst_triggered", 32'(triggered), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // normal rising ramp through 100
        capture(2'b00, 1'b0, 12'd100, 1'b0, 6'd0, 0, 90, 1'b0, k);
        chk("t1_model_trig", 32'(m_ch(m_trig, 0)), 32'd100);
        read_frame();
        chk("t1_read0", 32'(rd_ch(0, 0)), 32'd96);
        chk("t1_read4", 32'(rd_ch(4, 0)), 32'd100);
        chk("t1_read15", 32'(rd_ch(15, 0)), 32'd111);
        chk("t1_rearm_state", 32'(state), 32'd1);
        do_reset();

        // falling ramp on channel 1 through 50
        capture(2'b00, 1'b1, 12'd50, 1'b1, 6'd0, 1, 60, 1'b0, k);
        chk("t2_model_trig", 32'(m_ch(m_trig, 1)), 32'd49);
        read_frame();
        chk("t2_read4_ch1", 32'(rd_ch(4, 1)), 32'd49);
        chk("t2_read0_ch1", 32'(rd_ch(0, 1)), 32'd53);
        do_reset();

        // auto trigger on a flat signal
        capture(2'b01, 1'b0, 12'd100, 1'b0, 6'd0, 2, 20, 1'b0, k);
        chk("t3_accepted", 32'(k), 32'd79);
        read_frame();
        for (int j = 0; j < DEPTH; j++) chk("t3_flat", 32'(rd_ch(j, 0)), 32'd20);
        do_reset();

        // decimation 3 on a unit ramp
        capture(2'b00, 1'b0, 12'd200, 1'b0, 6'd3, 0, 150, 1'b0, k);
        chk("t4_model_trig", 32'(m_ch(m_trig, 0)), 32'd202);
        read_frame();
        chk("t4_read4", 32'(rd_ch(4, 0)), 32'd202);
        for (int j = 1; j < DEPTH; j++)
            chk("t4_step", 32'(rd_ch(j, 0) - rd_ch(j - 1, 0)), 32'd4);
        do_reset();

        // single shot returns to idle and stays there
        capture(2'b10, 1'b0, 12'd100, 1'b0, 6'd0, 0, 90, 1'b0, k);
        read_frame();
        chk("t5_state", 32'(state), 32'd0);
        chk("t5_frame_ready", 32'(frame_ready), 32'd0);
        bus.rd_en = 1'b1;
        bus.s_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("t5_rd_valid", 32'(bus.rd_valid), 32'd0);
            chk("t5_idle", 32'(state), 32'd0);
        end
        bus.rd_en = 1'b0;
        bus.s_valid = 1'b0;

        // reset during POST
        capture(2'b00, 1'b0, 12'd100, 1'b0, 6'd0, 0, 90, 1'b1, k);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("t6_state", 32'(state), 32'd0);
        chk("t6_triggered", 32'(triggered), 32'd0);
        chk("t6_frame_ready", 32'(frame_ready), 32'd0);
        chk("t6_rd_data", 32'(bus.rd_data), 32'd0);
        bus.rd_en = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("t6_rd_valid", 32'(bus.rd_valid), 32'd0);
        end
        bus.rd_en = 1'b0;
        capture(2'b00, 1'b0, 12'd100, 1'b0, 6'd0, 0, 90, 1'b0, k);
        read_frame();
        chk("t6_read4", 32'(rd_ch(4, 0)), 32'd100);
        do_reset();

        // random traffic, random configuration per arm, occasional reset
        for (int c = 0; c < 30000; c++) begin
            reset = ($urandom_range(0, 1999) != 0);
            arm = 1'b0;
            if (state == 3'd0 && $urandom_range(0, 7) == 0) begin
                mode = 2'($urandom_range(0, 3));
                trig_edge = 1'($urandom_range(0, 1));
                trig_sel = 1'($urandom_range(0, 1));
                decim = 6'($urandom_range(0, 3));
                trig_level = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom_range(0, 4095));
                arm = 1'b1;
            end else if ($urandom_range(0, 50) == 0) begin
                arm = 1'b1;
            end
            bus.s_valid = 1'($urandom_range(0, 1));
            bus.s_data = 24'($urandom);
            bus.rd_en = ($urandom_range(0, 2) != 0);
            @(negedge clk);
        end
        reset = 1'b1; arm = 1'b0; bus.s_valid = 1'b0; bus.rd_en = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/scope_capture.md
SCOPE_CAPTURE -- requirements
Module: scope_capture

Interface
REQ-001 SHALL have parameter CH, default 2, number of sampled channels (1..8).
REQ-002 SHALL have parameter W, default 12, ADC sample width per channel.
REQ-003 SHALL have parameter DEPTH, default 256, frame length in samples (power of 2, >=8).
REQ-004 SHALL have parameter PRE, default DEPTH/2, pre-trigger samples (1..DEPTH-1).
REQ-005 SHALL have parameter AUTO_TO, default 1024, accepted samples in ARMED before an auto-mode forced trigger.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 reset  in  1  synchronous, active-low; one clock; reset is synchronous and active-low.
REQ-008 s_valid  in  1  one-cycle strobe, new sample set on s_data.
REQ-009 s_data  in  CH*W  packed samples, channel k at bits [k*W +: W].
REQ-010 trig_sel  in  clog2(CH) (min 1)  trigger source channel.
REQ-011 trig_level  in  W  unsigned trigger threshold.
REQ-012 trig_edge  in  1  0 rising, 1 falling.
REQ-013 mode  in  2  00 normal, 01 auto, 10 single, 11 treated as normal.
REQ-014 decim  in  6  decimation; keep 1 of every decim+1 strobes.
REQ-015 arm  in  1  start-capture pulse.
REQ-016 rd_en  in  1  read request, one sample set per cycle.
REQ-017 rd_data  out  CH*W  frame data, oldest first.
REQ-018 rd_valid  out  1  rd_data valid, one cycle.
REQ-019 frame_ready  out  1  complete frame held, readable.
REQ-020 triggered  out  1  high in POST and READY.
REQ-021 state  out  3  IDLE=0, PRE=1, ARMED=2, POST=3, READY=4.

Function
REQ-022 Accepted sample SHALL be an s_valid strobe when the decimation counter is 0; counter counts strobes modulo decim+1, clears on entering PRE.
REQ-023 Only accepted samples SHALL be written to the DEPTH x CH*W circular buffer at wptr, wptr incrementing mod DEPTH.
REQ-024 IDLE: no writes; arm -> PRE, wptr=0, counters cleared; arm in any other state SHALL be ignored.
REQ-025 PRE: write accepted samples; trigger not evaluated; after PRE writes -> ARMED.
REQ-026 ARMED: write every accepted sample; rising trigger SHALL be prev < trig_level <= cur, falling prev >= trig_level > cur, unsigned, prev = previous accepted sample of channel trig_sel (including last PRE sample).
REQ-027 trig_sel >= CH SHALL select channel 0.
REQ-028 On trigger, trig_ptr SHALL latch the triggering sample's address and state -> POST on the next cycle.
REQ-029 Auto mode: ARMED SHALL count accepted samples; the AUTO_TO-th without a trigger SHALL itself be the trigger sample.
REQ-030 POST: write until DEPTH-PRE samples (trigger sample included) are stored, then -> READY; frame_ready=1.
REQ-031 READY: no writes; s_valid ignored; buffer contents frozen.
REQ-032 Readout SHALL start at (trig_ptr - PRE) mod DEPTH; rd_en in READY SHALL give rd_data and rd_valid=1 exactly one cycle later, address advancing mod DEPTH.
REQ-033 rd_en outside READY SHALL be ignored; rd_valid stays 0.
REQ-034 After the DEPTH-th read accepted: single -> IDLE; normal/auto -> PRE (re-armed, same init as REQ-024); frame_ready drops the same cycle; last rd_valid still issued.
REQ-035 Frame index PRE of readout SHALL be the trigger sample.

Reset
REQ-036 reset low at a clk edge SHALL force state IDLE, wptr, trig_ptr, read pointer, read count, auto and decimation counters to 0, rd_valid=0, frame_ready=0, triggered=0, rd_data=0, in any state incl. mid-readout; buffer contents need not clear.

Verification (CH=2, W=12, DEPTH=16, PRE=4, AUTO_TO=64)
REQ-037 Normal, rising, level 100, decim 0, ch0 ramp 90,91,... each strobe, arm -> 16 reads give 96..111; read 4 = 100; state returns PRE.
REQ-038 Falling, level 50, ch1 ramp down 60,59,... trig_sel=1 -> read 4 ch1 = 49, read 0 = 53.
REQ-039 Auto, ch0 constant 20, level 100 -> frame_ready after 4 PRE + 64 ARMED + 11 POST accepted samples; reads all 20.
REQ-040 decim=3, ch0 step-1 ramp -> consecutive readout samples differ by 4; trigger sample first crossing >= level.
REQ-041 Single mode -> after 16th read state=0, frame_ready=0; further rd_en gives rd_valid=0; s_valid ignored until arm.
REQ-042 reset low one cycle during POST -> next cycle state=0, triggered=0, frame_ready=0; rd_en ignored; arm restarts normally.
